// File: rtl/fighter_pkg.sv
// Shared definitions for the fighter controller: state encodings, timer sizing, knockback distance.
package fighter_pkg;

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        WALK_FWD     = 3'd1,
        WALK_BACK    = 3'd2,
        ATK_STARTUP  = 3'd3,
        ATK_ACTIVE   = 3'd4,
        ATK_RECOVERY = 3'd5,
        HITSTUN      = 3'd6,
        BLOCKSTUN    = 3'd7
    } fighter_state_t;

    localparam int unsigned KNOCKBACK_PX = 8;

    function automatic int unsigned max_frames(input int unsigned a, input int unsigned b,
                                               input int unsigned c, input int unsigned d,
                                               input int unsigned e);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        if (e > m) m = e;
        return m;
    endfunction

    function automatic int unsigned timer_width(input int unsigned max_fr);
        int unsigned w;
        w = $clog2(max_fr + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/frame_timer.sv
// Down-counting phase timer shared by all timed fighter states; holds at zero until reloaded.
module frame_timer #(
    parameter int unsigned W = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] count,
    output logic         zero
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (count != '0)
            count <= count - W'(1);
    end

    assign zero = (count == '0);

endmodule

// File: rtl/fighter_fsm.sv
// Per-player character controller: walking, three-phase attacks, hit/block stun, clamped position.
// Optional knockback on stun entry is compiled in with `define FIGHTER_KNOCKBACK_EN.
module fighter_fsm
    import fighter_pkg::*;
#(
    parameter int unsigned X_W          = 10,
    parameter int unsigned SCREEN_W     = 640,
    parameter int unsigned SPRITE_W     = 64,
    parameter int unsigned X_MIN        = 0,
    parameter int unsigned START_X      = 100,
    parameter int unsigned FACE_RIGHT   = 1,
    parameter int unsigned FWD_SPEED    = 3,
    parameter int unsigned BACK_SPEED   = 2,
    parameter int unsigned STARTUP_FR   = 3,
    parameter int unsigned ACTIVE_FR    = 2,
    parameter int unsigned RECOVERY_FR  = 6,
    parameter int unsigned HITSTUN_FR   = 6,
    parameter int unsigned BLOCKSTUN_FR = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           move_left,
    input  logic           move_right,
    input  logic           attack,
    input  logic           got_hit,
    output logic [X_W-1:0] char_x,
    output logic [2:0]     state,
    output logic           hitbox_active,
    output logic           in_stun
);

    localparam int unsigned X_MAX  = SCREEN_W - SPRITE_W;
    localparam int unsigned MAX_FR = max_frames(STARTUP_FR, ACTIVE_FR, RECOVERY_FR,
                                                HITSTUN_FR, BLOCKSTUN_FR);
    localparam int unsigned TW     = timer_width(MAX_FR);

    localparam logic [TW-1:0] LD_STARTUP   = TW'(STARTUP_FR - 1);
    localparam logic [TW-1:0] LD_ACTIVE    = TW'(ACTIVE_FR - 1);
    localparam logic [TW-1:0] LD_RECOVERY  = TW'(RECOVERY_FR - 1);
    localparam logic [TW-1:0] LD_HITSTUN   = TW'(HITSTUN_FR - 1);
    localparam logic [TW-1:0] LD_BLOCKSTUN = TW'(BLOCKSTUN_FR - 1);

    fighter_state_t cur_state, nxt_state;
    logic [X_W-1:0] x_q, x_d;
    logic           timer_load;
    logic [TW-1:0]  timer_val;
    logic [TW-1:0]  timer_count;
    logic           timer_zero;
    logic           one_dir, fwd, back;

    frame_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (timer_load),
        .load_val (timer_val),
        .count    (timer_count),
        .zero     (timer_zero)
    );

    assign one_dir = move_left ^ move_right;
    assign fwd     = one_dir & ((FACE_RIGHT != 0) ? move_right : move_left);
    assign back    = one_dir & ((FACE_RIGHT != 0) ? move_left  : move_right);

    // Saturating moves; comparisons are rearranged so nothing underflows.
    function automatic logic [X_W-1:0] step_left(input logic [X_W-1:0] x, input int unsigned spd);
        int unsigned xi;
        xi = 32'(x);
        return (xi < X_MIN + spd) ? X_W'(X_MIN) : X_W'(xi - spd);
    endfunction

    function automatic logic [X_W-1:0] step_right(input logic [X_W-1:0] x, input int unsigned spd);
        int unsigned xi;
        xi = 32'(x);
        return (xi + spd > X_MAX) ? X_W'(X_MAX) : X_W'(xi + spd);
    endfunction

    function automatic logic [X_W-1:0] step_fwd(input logic [X_W-1:0] x, input int unsigned spd);
        return (FACE_RIGHT != 0) ? step_right(x, spd) : step_left(x, spd);
    endfunction

    function automatic logic [X_W-1:0] step_back(input logic [X_W-1:0] x, input int unsigned spd);
        return (FACE_RIGHT != 0) ? step_left(x, spd) : step_right(x, spd);
    endfunction

    always_comb begin
        nxt_state  = cur_state;
        x_d        = x_q;
        timer_load = 1'b0;
        timer_val  = '0;
        case (cur_state)
            IDLE, WALK_FWD, WALK_BACK: begin
                if (got_hit) begin
                    timer_load = 1'b1;
                    if (back) begin
                        nxt_state = BLOCKSTUN;
                        timer_val = LD_BLOCKSTUN;
`ifdef FIGHTER_KNOCKBACK_EN
                        x_d = step_back(x_q, KNOCKBACK_PX / 2);
`endif
                    end else begin
                        nxt_state = HITSTUN;
                        timer_val = LD_HITSTUN;
`ifdef FIGHTER_KNOCKBACK_EN
                        x_d = step_back(x_q, KNOCKBACK_PX);
`endif
                    end
                end else if (attack) begin
                    nxt_state  = ATK_STARTUP;
                    timer_load = 1'b1;
                    timer_val  = LD_STARTUP;
                end else if (fwd) begin
                    nxt_state = WALK_FWD;
                    x_d       = step_fwd(x_q, FWD_SPEED);
                end else if (back) begin
                    nxt_state = WALK_BACK;
                    x_d       = step_back(x_q, BACK_SPEED);
                end else begin
                    nxt_state = IDLE;
                end
            end
            ATK_STARTUP, ATK_ACTIVE, ATK_RECOVERY: begin
                if (got_hit) begin
                    nxt_state  = HITSTUN;
                    timer_load = 1'b1;
                    timer_val  = LD_HITSTUN;
`ifdef FIGHTER_KNOCKBACK_EN
                    x_d = step_back(x_q, KNOCKBACK_PX);
`endif
                end else if (timer_zero) begin
                    timer_load = 1'b1;
                    if (cur_state == ATK_STARTUP) begin
                        nxt_state = ATK_ACTIVE;
                        timer_val = LD_ACTIVE;
                    end else if (cur_state == ATK_ACTIVE) begin
                        nxt_state = ATK_RECOVERY;
                        timer_val = LD_RECOVERY;
                    end else begin
                        nxt_state  = IDLE;
                        timer_load = 1'b0;
                    end
                end
            end
            HITSTUN, BLOCKSTUN: begin
                if (timer_zero)
                    nxt_state = IDLE;
            end
            default: nxt_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_state     <= IDLE;
            x_q           <= X_W'(START_X);
            hitbox_active <= 1'b0;
            in_stun       <= 1'b0;
        end else begin
            cur_state     <= nxt_state;
            x_q           <= x_d;
            hitbox_active <= (nxt_state == ATK_ACTIVE);
            in_stun       <= (nxt_state == HITSTUN) || (nxt_state == BLOCKSTUN);
        end
    end

    // The timer is only ever loaded with a phase length minus one.
    always_ff @(posedge clk) begin
        if (!reset)
            assert (32'(timer_count) < MAX_FR);
    end

    assign state  = cur_state;
    assign char_x = x_q;

endmodule
